// File: rtl/pe_param.sv
`timescale 1ns/1ps
// Parametrised PE: buffers a filter, a sliding ifmap window and partial sums in
// local scratchpads, runs one signed MAC per cycle and streams psums out.
module pe_param #(
    parameter int DATA_BITS       = 32,
    parameter int ELEM_BITS       = 8,
    parameter int PSUM_BITS       = 32,
    parameter int IFMAP_SPAD_LEN  = 16,
    parameter int FILTER_SPAD_LEN = 64,
    parameter int PSUM_SPAD_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PE_en,
    input  logic [13:0]          i_config,
    input  logic [DATA_BITS-1:0] ifmap,
    input  logic [DATA_BITS-1:0] filter,
    input  logic [DATA_BITS-1:0] ipsum,
    input  logic                 ifmap_valid,
    input  logic                 filter_valid,
    input  logic                 ipsum_valid,
    output logic                 ifmap_ready,
    output logic                 filter_ready,
    output logic                 ipsum_ready,
    output logic [DATA_BITS-1:0] opsum,
    output logic                 opsum_valid,
    input  logic                 opsum_ready
);

    localparam int LANES = DATA_BITS / ELEM_BITS;
    localparam int FCW   = $clog2(FILTER_SPAD_LEN + 1);
    localparam int ICW   = $clog2(IFMAP_SPAD_LEN + 1);
    localparam int FAW   = $clog2(FILTER_SPAD_LEN);
    localparam int IAW   = $clog2(IFMAP_SPAD_LEN);
    localparam int PAW   = $clog2(PSUM_SPAD_LEN);
    localparam logic [ELEM_BITS-1:0] SIGN_FLIP = {1'b1, {(ELEM_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, READ_FILTER, READ_IFMAP, READ_IPSUM, CONV, WRITE_OPSUM
    } state_t;

    state_t state_q, state_d;

    logic       stride2_q, stride2_d;
    logic       dw_q, dw_d;
    logic [1:0] rs_m1_q, rs_m1_d;
    logic [1:0] p_m1_q, p_m1_d;
    logic [1:0] q_m1_q, q_m1_d;
    logic [4:0] f_last_q, f_last_d;
    logic       cfg_unused;

    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic [ICW-1:0] ifm_cnt_q, ifm_cnt_d;
    logic [PAW-1:0] ipsum_cnt_q, ipsum_cnt_d;
    logic [IAW-1:0] mac_j_q, mac_j_d;
    logic [PAW-1:0] mac_k_q, mac_k_d;
    logic [FAW-1:0] mac_ptr_q, mac_ptr_d;
    logic [PAW-1:0] opsum_idx_q, opsum_idx_d;
    logic [4:0]     col_q, col_d;

    logic [ELEM_BITS-1:0] filter_spad_q [FILTER_SPAD_LEN];
    logic [ELEM_BITS-1:0] filter_spad_d [FILTER_SPAD_LEN];
    logic [ELEM_BITS-1:0] ifmap_spad_q  [IFMAP_SPAD_LEN];
    logic [ELEM_BITS-1:0] ifmap_spad_d  [IFMAP_SPAD_LEN];
    logic [PSUM_BITS-1:0] psum_q        [PSUM_SPAD_LEN];
    logic [PSUM_BITS-1:0] psum_d        [PSUM_SPAD_LEN];

    logic [2:0] q_val, p_val, rs_val, np_val;
    logic [4:0] w_val;
    logic [6:0] nf_val;
    logic [3:0] sh_val;
    logic       last_j, last_mac;

    logic signed [2*ELEM_BITS-1:0]        prod;
    logic        [PSUM_BITS-1:0]          prod_ext;
    logic        [IFMAP_SPAD_LEN*ELEM_BITS-1:0] ifmap_flat, ifmap_shifted;

    assign cfg_unused = i_config[9];

    assign q_val   = {1'b0, q_m1_q} + 3'd1;
    assign p_val   = {1'b0, p_m1_q} + 3'd1;
    assign rs_val  = {1'b0, rs_m1_q} + 3'd1;
    assign w_val   = 5'(q_val) * 5'(rs_val);
    assign nf_val  = dw_q ? 7'(w_val) : 7'(p_val) * 7'(w_val);
    assign np_val  = dw_q ? q_val : p_val;
    assign sh_val  = stride2_q ? {q_val, 1'b0} : {1'b0, q_val};

    assign prod     = $signed(filter_spad_q[mac_ptr_q]) * $signed(ifmap_spad_q[mac_j_q]);
    assign prod_ext = {{(PSUM_BITS-2*ELEM_BITS){prod[2*ELEM_BITS-1]}}, prod};

    // Depthwise accumulates into psum[j mod q], so mac_k wraps every q MACs there.
    assign last_j   = (mac_j_q == IAW'(w_val - 5'd1));
    assign last_mac = dw_q ? last_j : (last_j && (mac_k_q == PAW'(p_val - 3'd1)));

    always_comb begin
        ifmap_flat = '0;
        for (int i = 0; i < IFMAP_SPAD_LEN; i++) begin
            ifmap_flat[i*ELEM_BITS +: ELEM_BITS] = ifmap_spad_q[i];
        end
        ifmap_shifted = ifmap_flat >> (int'(sh_val) * ELEM_BITS);
    end

    always_comb begin
        filter_ready = (state_q == READ_FILTER);
        ifmap_ready  = (state_q == READ_IFMAP);
        ipsum_ready  = (state_q == READ_IPSUM);
        opsum_valid  = (state_q == WRITE_OPSUM);
        opsum        = '0;
        if (state_q == WRITE_OPSUM) begin
            opsum = DATA_BITS'(psum_q[opsum_idx_q]);
        end
    end

    always_comb begin
        state_d       = state_q;
        stride2_d     = stride2_q;
        dw_d          = dw_q;
        rs_m1_d       = rs_m1_q;
        p_m1_d        = p_m1_q;
        q_m1_d        = q_m1_q;
        f_last_d      = f_last_q;
        filt_cnt_d    = filt_cnt_q;
        ifm_cnt_d     = ifm_cnt_q;
        ipsum_cnt_d   = ipsum_cnt_q;
        mac_j_d       = mac_j_q;
        mac_k_d       = mac_k_q;
        mac_ptr_d     = mac_ptr_q;
        opsum_idx_d   = opsum_idx_q;
        col_d         = col_q;
        filter_spad_d = filter_spad_q;
        ifmap_spad_d  = ifmap_spad_q;
        psum_d        = psum_q;

        case (state_q)
            IDLE: begin
                filt_cnt_d  = '0;
                ifm_cnt_d   = '0;
                ipsum_cnt_d = '0;
                mac_j_d     = '0;
                mac_k_d     = '0;
                mac_ptr_d   = '0;
                opsum_idx_d = '0;
                col_d       = '0;
                for (int i = 0; i < FILTER_SPAD_LEN; i++) filter_spad_d[i] = '0;
                for (int i = 0; i < IFMAP_SPAD_LEN; i++)  ifmap_spad_d[i]  = '0;
                for (int i = 0; i < PSUM_SPAD_LEN; i++)   psum_d[i]        = '0;
                if (PE_en) begin
                    stride2_d = i_config[13];
                    dw_d      = i_config[12];
                    rs_m1_d   = i_config[11:10];
                    p_m1_d    = i_config[8:7];
                    f_last_d  = i_config[6:2];
                    q_m1_d    = i_config[1:0];
                    state_d   = READ_FILTER;
                end
            end
            READ_FILTER: begin
                if (filt_cnt_q >= FCW'(nf_val)) begin
                    state_d = READ_IFMAP;
                end else if (filter_valid) begin
                    for (int i = 0; i < FILTER_SPAD_LEN; i++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (l < int'(q_val) && int'(filt_cnt_q) + l == i) begin
                                filter_spad_d[i] = filter[l*ELEM_BITS +: ELEM_BITS];
                            end
                        end
                    end
                    filt_cnt_d = filt_cnt_q + FCW'(q_val);
                end
            end
            READ_IFMAP: begin
                if (ifm_cnt_q >= ICW'(w_val)) begin
                    state_d = READ_IPSUM;
                end else if (ifmap_valid) begin
                    for (int i = 0; i < IFMAP_SPAD_LEN; i++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (l < int'(q_val) && int'(ifm_cnt_q) + l == i) begin
                                ifmap_spad_d[i] = ifmap[l*ELEM_BITS +: ELEM_BITS] ^ SIGN_FLIP;
                            end
                        end
                    end
                    ifm_cnt_d = ifm_cnt_q + ICW'(q_val);
                end
            end
            READ_IPSUM: begin
                if (ipsum_valid) begin
                    psum_d[ipsum_cnt_q] = PSUM_BITS'(ipsum);
                    ipsum_cnt_d         = ipsum_cnt_q + 1'b1;
                    if (ipsum_cnt_q == PAW'(np_val - 3'd1)) begin
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                psum_d[mac_k_q] = psum_q[mac_k_q] + prod_ext;
                mac_ptr_d       = mac_ptr_q + 1'b1;
                mac_j_d         = last_j ? '0 : mac_j_q + 1'b1;
                if (dw_q) begin
                    mac_k_d = (mac_k_q == PAW'(q_val - 3'd1)) ? '0 : mac_k_q + 1'b1;
                end else if (last_j) begin
                    mac_k_d = mac_k_q + 1'b1;
                end
                if (last_mac) begin
                    state_d = WRITE_OPSUM;
                end
            end
            WRITE_OPSUM: begin
                if (opsum_ready) begin
                    opsum_idx_d = opsum_idx_q + 1'b1;
                    if (opsum_idx_q == PAW'(np_val - 3'd1)) begin
                        if (col_q == f_last_q) begin
                            state_d = IDLE;
                        end else begin
                            // Slide the window: keep the overlap, refill S beats at the tail.
                            col_d       = col_q + 5'd1;
                            ifm_cnt_d   = (ifm_cnt_q > ICW'(sh_val)) ? ifm_cnt_q - ICW'(sh_val) : '0;
                            ipsum_cnt_d = '0;
                            mac_j_d     = '0;
                            mac_k_d     = '0;
                            mac_ptr_d   = '0;
                            opsum_idx_d = '0;
                            for (int i = 0; i < IFMAP_SPAD_LEN; i++) begin
                                ifmap_spad_d[i] = ifmap_shifted[i*ELEM_BITS +: ELEM_BITS];
                            end
                            for (int i = 0; i < PSUM_SPAD_LEN; i++) psum_d[i] = '0;
                            state_d = READ_IFMAP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stride2_q   <= 1'b0;
            dw_q        <= 1'b0;
            rs_m1_q     <= '0;
            p_m1_q      <= '0;
            q_m1_q      <= '0;
            f_last_q    <= '0;
            filt_cnt_q  <= '0;
            ifm_cnt_q   <= '0;
            ipsum_cnt_q <= '0;
            mac_j_q     <= '0;
            mac_k_q     <= '0;
            mac_ptr_q   <= '0;
            opsum_idx_q <= '0;
            col_q       <= '0;
            for (int i = 0; i < FILTER_SPAD_LEN; i++) filter_spad_q[i] <= '0;
            for (int i = 0; i < IFMAP_SPAD_LEN; i++)  ifmap_spad_q[i]  <= '0;
            for (int i = 0; i < PSUM_SPAD_LEN; i++)   psum_q[i]        <= '0;
        end else begin
            state_q       <= state_d;
            stride2_q     <= stride2_d;
            dw_q          <= dw_d;
            rs_m1_q       <= rs_m1_d;
            p_m1_q        <= p_m1_d;
            q_m1_q        <= q_m1_d;
            f_last_q      <= f_last_d;
            filt_cnt_q    <= filt_cnt_d;
            ifm_cnt_q     <= ifm_cnt_d;
            ipsum_cnt_q   <= ipsum_cnt_d;
            mac_j_q       <= mac_j_d;
            mac_k_q       <= mac_k_d;
            mac_ptr_q     <= mac_ptr_d;
            opsum_idx_q   <= opsum_idx_d;
            col_q         <= col_d;
            filter_spad_q <= filter_spad_d;
            ifmap_spad_q  <= ifmap_spad_d;
            psum_q        <= psum_d;
        end
    end

endmodule

// File: tb/tb_pe_param.sv
`timescale 1ns/1ps
// Bench for pe_param: directed scenarios plus randomized jobs checked against a
// window-over-stream convolution model.
module tb_pe_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        PE_en;
    logic [13:0] i_config;
    logic [31:0] ifmap, filter, ipsum;
    logic        ifmap_valid, filter_valid, ipsum_valid;
    logic        ifmap_ready, filter_ready, ipsum_ready;
    logic [31:0] opsum;
    logic        opsum_valid;
    logic        opsum_ready;

    int checks = 0;
    int errors = 0;
    int stallFirst = 0;

    logic [7:0]  filtVals  [64];
    logic [7:0]  stream    [300];
    logic [31:0] ipsumVals [128];
    logic [31:0] expOpsum  [128];

    always #5 clk = ~clk;

    pe_param dut (
        .clk(clk), .rst(rst), .PE_en(PE_en), .i_config(i_config),
        .ifmap(ifmap), .filter(filter), .ipsum(ipsum),
        .ifmap_valid(ifmap_valid), .filter_valid(filter_valid), .ipsum_valid(ipsum_valid),
        .ifmap_ready(ifmap_ready), .filter_ready(filter_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic finishRun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic int elemToInt(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Window for column c is simply stream[c*S*q .. c*S*q+W-1], signed after the 0x80 flip.
    task automatic buildExpected(input int q, input int p, input int rs, input int lastCol,
                                 input int s, input int dw);
        int w;
        int np;
        int x;
        int f;
        logic [31:0] acc [4];
        w  = q * rs;
        np = dw ? q : p;
        for (int c = 0; c <= lastCol; c++) begin
            for (int k = 0; k < np; k++) acc[k] = ipsumVals[c*np + k];
            for (int j = 0; j < w; j++) begin
                x = elemToInt(stream[c*s*q + j] ^ 8'h80);
                if (dw) begin
                    f = elemToInt(filtVals[j]);
                    acc[j % q] = acc[j % q] + 32'(f * x);
                end else begin
                    for (int k = 0; k < np; k++) begin
                        f = elemToInt(filtVals[k*w + j]);
                        acc[k] = acc[k] + 32'(f * x);
                    end
                end
            end
            for (int k = 0; k < np; k++) expOpsum[c*np + k] = acc[k];
        end
    endtask

    task automatic driveBus(input int bus, input logic v, input logic [31:0] data);
        case (bus)
            0: begin filter_valid = v; filter = data; end
            1: begin ifmap_valid  = v; ifmap  = data; end
            default: begin ipsum_valid = v; ipsum = data; end
        endcase
    endtask

    function automatic logic busReady(input int bus);
        case (bus)
            0: return filter_ready;
            1: return ifmap_ready;
            default: return ipsum_ready;
        endcase
    endfunction

    task automatic dropAll();
        @(negedge clk);
        filter_valid = 1'b0;
        ifmap_valid  = 1'b0;
        ipsum_valid  = 1'b0;
    endtask

    task automatic sendBeat(input int bus, input logic [31:0] data, input string tag);
        int waited;
        int gaps;
        waited = 0;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            driveBus(bus, 1'b0, 32'($urandom));
        end
        @(negedge clk);
        driveBus(bus, 1'b1, data);
        while (!busReady(bus)) begin
            if (waited >= 200) begin
                checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
                finishRun();
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
    endtask

    task automatic receiveOpsums(input int np, input int base, input int convLen);
        int n;
        int stalls;
        bit rdy;
        n = 0;
        while (!opsum_valid) begin
            if (n >= 300) begin
                checkOutput("opsum_timeout", 32'd0, 32'd1);
                finishRun();
            end
            @(negedge clk);
            n++;
        end
        checkOutput("conv_cycles", 32'(n), 32'(convLen));
        for (int k = 0; k < np; k++) begin
            stalls = 0;
            rdy = 1'b0;
            while (!rdy) begin
                if (k == 0 && stallFirst > 0) rdy = (stalls >= stallFirst);
                else rdy = (stalls >= 3) || ($urandom_range(0, 1) == 1);
                opsum_ready = rdy;
                checkOutput("opsum_valid", 32'(opsum_valid), 32'd1);
                checkOutput($sformatf("opsum%0d", base + k), opsum, expOpsum[base + k]);
                @(posedge clk);
                @(negedge clk);
                opsum_ready = 1'b0;
                stalls++;
            end
        end
    endtask

    task automatic applyStimulus(input int q, input int p, input int rs, input int lastCol,
                                 input int s2, input int dw, input bit resetInConv);
        int w;
        int nf;
        int np;
        int s;
        int beats;
        int off;
        logic [31:0] data;
        w  = q * rs;
        nf = dw ? w : p * w;
        np = dw ? q : p;
        s  = s2 ? 2 : 1;
        buildExpected(q, p, rs, lastCol, s, dw);

        @(negedge clk);
        PE_en    = 1'b1;
        i_config = {1'(s2), 1'(dw), 2'(rs - 1), 1'b0, 2'(p - 1), 5'(lastCol), 2'(q - 1)};
        @(negedge clk);
        PE_en    = 1'b0;
        i_config = 14'($urandom);

        for (int b = 0; b < nf / q; b++) begin
            data = $urandom;
            for (int l = 0; l < q; l++) data[8*l +: 8] = filtVals[b*q + l];
            sendBeat(0, data, "filter");
        end
        dropAll();

        for (int c = 0; c <= lastCol; c++) begin
            beats = (c == 0) ? rs : s;
            off   = (c == 0) ? 0 : w + (c - 1) * s * q;
            for (int b = 0; b < beats; b++) begin
                data = $urandom;
                for (int l = 0; l < q; l++) data[8*l +: 8] = stream[off + b*q + l];
                sendBeat(1, data, "ifmap");
            end
            dropAll();
            for (int k = 0; k < np; k++) sendBeat(2, ipsumVals[c*np + k], "ipsum");
            dropAll();
            if (resetInConv) begin
                checkOutput("pre_reset_valid", 32'(opsum_valid), 32'd0);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("reset_abort_flags",
                            {28'd0, filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 32'd0);
                checkOutput("reset_abort_opsum", opsum, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    checkOutput("post_reset_valid", 32'(opsum_valid), 32'd0);
                end
                return;
            end
            receiveOpsums(np, c * np, dw ? w : p * w);
        end
        checkOutput("idle_flags", {28'd0, filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 32'd0);
        checkOutput("idle_opsum", opsum, 32'd0);
    endtask

    task automatic loadBasic();
        filtVals[0] = 8'd1; filtVals[1] = 8'd2; filtVals[2] = 8'd3;
        for (int i = 0; i < 5; i++) stream[i] = 8'(8'h81 + i);
    endtask

    initial begin
        #400000;
        checkOutput("watchdog", 32'd0, 32'd1);
        finishRun();
    end

    initial begin
        int q, p, rs, dw, s2, lastCol, w, nf, np, s;
        rst = 1'b1; PE_en = 1'b0; i_config = '0;
        ifmap = '0; filter = '0; ipsum = '0;
        ifmap_valid = 1'b0; filter_valid = 1'b0; ipsum_valid = 1'b0; opsum_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", {28'd0, filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 32'd0);
        checkOutput("reset_opsum", opsum, 32'd0);
        rst = 1'b0;

        $display("[TB] standard stride 1");
        loadBasic();
        ipsumVals[0] = 32'd10; ipsumVals[1] = 32'd0;
        applyStimulus(1, 1, 3, 1, 0, 0, 1'b0);

        $display("[TB] stride 2");
        loadBasic();
        ipsumVals[0] = 32'd0; ipsumVals[1] = 32'd0;
        applyStimulus(1, 1, 3, 1, 1, 0, 1'b0);

        $display("[TB] depthwise");
        filtVals[0] = 8'd1; filtVals[1] = 8'd1; filtVals[2] = 8'd2; filtVals[3] = 8'd2;
        for (int i = 0; i < 4; i++) stream[i] = 8'(8'h83 + i);
        ipsumVals[0] = 32'd0; ipsumVals[1] = 32'd0;
        applyStimulus(2, 1, 2, 0, 0, 1, 1'b0);

        $display("[TB] sign and wrap");
        filtVals[0] = 8'hFF; stream[0] = 8'h00; ipsumVals[0] = 32'hFFFF_FFFF;
        applyStimulus(1, 1, 1, 0, 0, 0, 1'b0);
        filtVals[0] = 8'h01; stream[0] = 8'h81; ipsumVals[0] = 32'h7FFF_FFFF;
        applyStimulus(1, 1, 1, 0, 0, 0, 1'b0);

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) filtVals[i] = 8'($urandom);
        for (int i = 0; i < 2; i++) stream[i] = 8'($urandom);
        ipsumVals[0] = $urandom; ipsumVals[1] = $urandom;
        stallFirst = 3;
        applyStimulus(1, 2, 2, 0, 0, 0, 1'b0);
        stallFirst = 0;

        $display("[TB] reset during conv");
        loadBasic();
        ipsumVals[0] = 32'd10; ipsumVals[1] = 32'd0;
        applyStimulus(1, 1, 3, 1, 0, 0, 1'b1);
        applyStimulus(1, 1, 3, 1, 0, 0, 1'b0);

        $display("[TB] randomized jobs");
        for (int t = 0; t < 16; t++) begin
            q  = int'($urandom_range(1, 4));
            p  = int'($urandom_range(1, 4));
            rs = int'($urandom_range(1, 4));
            dw = int'($urandom_range(0, 1));
            s2 = int'($urandom_range(0, 1));
            if (s2 != 0 && rs < 2) rs = 2;
            lastCol = int'($urandom_range(0, 3));
            s  = s2 ? 2 : 1;
            w  = q * rs;
            nf = dw ? w : p * w;
            np = dw ? q : p;
            for (int i = 0; i < nf; i++) filtVals[i] = 8'($urandom);
            for (int i = 0; i < w + lastCol * s * q; i++) stream[i] = 8'($urandom);
            for (int i = 0; i < (lastCol + 1) * np; i++) ipsumVals[i] = $urandom;
            applyStimulus(q, p, rs, lastCol, s2, dw, 1'b0);
        end

        finishRun();
    end

endmodule

// File: doc/pe_param.md
# pe_param

Parametrised successor processing element for the PE array: buffers a filter, a sliding ifmap window and partial sums in local scratchpads, runs one signed MAC per cycle, and streams output partial sums over valid/ready handshakes. Adds generic element/spad sizing, stride-2 window sliding, and depthwise-correct filter sizing. It sits in each PE array slot, fed by the GLB/NoC ifmap, filter and ipsum buses.

## Interface
- DATA_BITS, 32, bus width of ifmap/filter/ipsum/opsum
- ELEM_BITS, 8, ifmap and filter element width; LANES = DATA_BITS/ELEM_BITS (4)
- PSUM_BITS, 32, psum spad entry width (must equal DATA_BITS)
- IFMAP_SPAD_LEN, 16, ifmap entries
- FILTER_SPAD_LEN, 64, filter entries
- PSUM_SPAD_LEN, 4, psum entries
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- PE_en  in  1  start pulse; config latched when sampled in IDLE
- i_config  in  14  [13] stride2, [12] depthwise, [11:10] rs-1, [9] reserved, [8:7] p-1, [6:2] F (output columns-1), [1:0] q-1
- ifmap, filter, ipsum  in  DATA_BITS  data buses; element i in bits [ELEM_BITS*i +: ELEM_BITS]
- ifmap_valid, filter_valid, ipsum_valid  in  1  source valid
- ifmap_ready, filter_ready, ipsum_ready  out  1  sink ready
- opsum  out  DATA_BITS  output psum
- opsum_valid  out  1
- opsum_ready  in  1

## Operation
- States: IDLE, READ_FILTER, READ_IFMAP, READ_IPSUM, CONV, WRITE_OPSUM.
- Derived: q,p,rs in 1..4; S = stride2?2:1; W = q*rs (window); NF = depthwise ? W : p*W; NP = depthwise ? q : p.
- IDLE: all counters/spads cleared; PE_en=1 latches config, -> READ_FILTER. PE_en ignored elsewhere.
- READ_FILTER: per accepted beat, lanes 0..q-1 written to filter[cnt..cnt+q-1], cnt += q; when cnt == NF -> READ_IFMAP (checked registered, one cycle after last beat).
- READ_IFMAP: per beat, lanes 0..q-1 XOR 0x80 (unsigned to signed) appended at ifmap[cnt]; when cnt == W -> READ_IPSUM.
- READ_IPSUM: beat k loads psum[k]; after beat NP-1 accepted -> CONV same edge.
- CONV, one MAC/cycle: standard, for k in 0..p-1, j in 0..W-1: psum[k] += filter[k*W+j]*ifmap[j]; depthwise, for j in 0..W-1: psum[j mod q] += filter[j]*ifmap[j]. After last MAC -> WRITE_OPSUM.
- WRITE_OPSUM: opsum = psum[idx], idx 0..NP-1, advances on opsum_valid&&opsum_ready. After last beat: if col == F -> IDLE; else col++, shift ifmap down by S*q (vacated entries 0), ifmap cnt -= S*q, psum/conv counters cleared, filter kept, -> READ_IFMAP (refill S beats).
- Arithmetic: ELEM_BITS x ELEM_BITS signed product, sign-extended to PSUM_BITS, accumulation wraps mod 2^PSUM_BITS.
- Configs with W > IFMAP_SPAD_LEN or NF > FILTER_SPAD_LEN are illegal; behaviour undefined.

## Timing
- Reset: state IDLE; all ready/valid outputs 0; opsum 0; all spads and counters 0. Reset mid-operation aborts on the next edge, no outputs issued after.
- ready/valid outputs are combinational from state only: filter_ready=READ_FILTER, ifmap_ready=READ_IFMAP, ipsum_ready=READ_IPSUM, opsum_valid=WRITE_OPSUM.
- Beat accepted on edge where valid&&ready; valid without ready holds nothing.
- CONV lasts exactly p*W cycles (standard) or W cycles (depthwise).
- opsum stable while opsum_valid&&!opsum_ready; no combinational path from any valid to any ready.
- Stride-2 refill on last column window identical to stride 1 except two ifmap beats.

## Test plan
- Standard q=1,p=1,rs=3,F=1,S=1: filter 1,2,3; ifmap 0x81,0x82,0x83; ipsum 10 -> opsum 24; push 0x84, ipsum 0 -> opsum 20; then IDLE, all readies 0.
- Stride 2, q=1,rs=3,F=1: filter 1,2,3; ifmap 1,2,3 (0x81..0x83), ipsum 0 -> 14; two beats 0x84,0x85, ipsum 0 -> 26.
- Depthwise q=2,rs=2: filter beats {1,1},{2,2}; ifmap {0x83,0x84},{0x85,0x86}; ipsums 0,0 -> opsum 13 then 16; CONV exactly 4 cycles.
- Sign/wrap: filter 0xFF, ifmap 0x00, ipsum 0xFFFFFFFF, q=p=rs=1 -> opsum 127; ipsum 0x7FFFFFFF with product +1 -> 0x80000000.
- Backpressure: opsum_ready low 3 cycles in WRITE_OPSUM -> opsum_valid=1, opsum unchanged, idx unchanged; p=2 delivers both psums in order.
- Reset asserted during CONV -> next cycle IDLE, opsum_valid 0, fresh run yields correct 24 from first scenario.
